sspi_host_master: RTL

Host-side SPI initiator for the monitor core's slave SPI command port (`sspi_*`). It accepts command requests from a local controller and serialises the command byte plus its command-dependent payload in one chip-select frame. It also performs single-byte receive frames that read the core's reply stream. It sits in the host/companion FPGA and drives `sspi_cs/clk/mosi`, sampling `sspi_miso`.

---
 rtl/sspi_pkg.sv | 31 +++
 rtl/sspi_shift_byte.sv | 72 +++++++
 rtl/sspi_host_master.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/sspi_pkg.sv
// Shared constants, FSM encoding and payload sizing for the SPI host master.
package sspi_pkg;

  localparam logic [7:0] CMD_GET_CFG = 8'd1;
  localparam logic [7:0] CMD_SET_CFG = 8'd2;
  localparam logic [7:0] CMD_2B      = 8'd4;
  localparam logic [7:0] CMD_STREAM  = 8'd7;

  // Frame sequencer states; the LO/HI bit phases live inside the shift engine
  // while the sequencer sits in ST_SHIFT.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LOAD,
    ST_SHIFT,
    ST_END,
    ST_GAP
  } state_t;

  // Fixed payload bytes that follow the command byte (stream bytes excluded).
  function automatic logic [2:0] payload_bytes(input logic [7:0] cmd);
    case (cmd)
      CMD_GET_CFG: payload_bytes = 3'd1;
      CMD_SET_CFG: payload_bytes = 3'd4;
      CMD_2B:      payload_bytes = 3'd2;
      CMD_STREAM:  payload_bytes = 3'd3;
      default:     payload_bytes = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/sspi_shift_byte.sv
// One-byte SPI mode-0 shift engine: CLK_DIV-clock low and high phases per bit,
// MSB first, MISO sampled on the clock edge where sspi_clk rises.
// A start in the final cycle of a byte (done=1) chains the next byte with no gap.
module sspi_shift_byte #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_byte,
  output logic       done,
  output logic       rx_last,
  output logic [7:0] rx_byte,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  logic        active;
  logic        hi;
  logic [15:0] div;
  logic [2:0]  bitn;
  logic [7:0]  tx_sh;
  logic [7:0]  rx_sh;
  logic        div_end;

  assign div_end = (div == DIV_LAST);
  assign done    = active & hi & div_end & (bitn == 3'd0);
  assign sclk    = active & hi;
  assign mosi    = active & tx_sh[7];
  assign rx_byte = rx_sh;

  // Phase/bit counters and the transmit/receive shift registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active  <= 1'b0;
      hi      <= 1'b0;
      div     <= 16'd0;
      bitn    <= 3'd0;
      tx_sh   <= 8'h00;
      rx_sh   <= 8'h00;
      rx_last <= 1'b0;
    end else begin
      rx_last <= active & ~hi & div_end & (bitn == 3'd0) & ~start;
      if (start) begin
        active <= 1'b1;
        hi     <= 1'b0;
        div    <= 16'd0;
        bitn   <= 3'd7;
        tx_sh  <= tx_byte;
      end else if (active) begin
        if (!div_end) begin
          div <= div + 16'd1;
        end else begin
          div <= 16'd0;
          if (!hi) begin
            hi    <= 1'b1;
            rx_sh <= {rx_sh[6:0], miso};
          end else begin
            hi    <= 1'b0;
            tx_sh <= {tx_sh[6:0], 1'b0};
            if (bitn == 3'd0) active <= 1'b0;
            else              bitn   <= bitn - 3'd1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/sspi_host_master.sv
// Host-side SPI initiator: one CS frame per request carrying the command byte
// and its payload, or a single-byte receive frame reading the core's replies.
// Handshake: a request transfers on a clock edge where req_valid and req_ready
// are both high; a stream byte transfers on an edge where dat_ready is high,
// and dat_ready is only raised while dat_valid is high.
module sspi_host_master
  import sspi_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int CS_SETUP = 4,
  parameter int CS_GAP   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rx,
  input  logic [7:0]  req_cmd,
  input  logic [31:0] req_arg,
  input  logic [23:0] req_len,
  input  logic        dat_valid,
  input  logic [7:0]  dat,
  output logic        dat_ready,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  output logic        busy,
  output logic        sspi_cs,
  output logic        sspi_clk,
  output logic        sspi_mosi,
  input  logic        sspi_miso,
  output state_t      state_dbg
);

  localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
  localparam logic [15:0] END_LAST   = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST   = 16'(CS_GAP - 1);

  state_t      state, state_n;
  logic [15:0] cnt;
  logic [26:0] idx;
  logic [26:0] total;
  logic        armed;
  logic        accept;
  logic        lat_rx;
  logic [7:0]  lat_cmd;
  logic [31:0] lat_arg;
  logic [23:0] lat_len;
  logic [7:0]  byte_sel;
  logic        need_stream;
  logic        avail;
  logic        start;
  logic        sh_done;
  logic        sh_rx_last;
  logic [7:0]  sh_rx_byte;

  assign req_ready = armed & (state == ST_IDLE);
  assign accept    = req_ready & req_valid;
  assign busy      = (state != ST_IDLE);
  assign sspi_cs   = ~((state == ST_SETUP) | (state == ST_LOAD) |
                       (state == ST_SHIFT) | (state == ST_END));
  assign state_dbg = state;

  // Bytes in the frame: command + fixed payload + stream length for cmd 7.
  always_comb begin
    total = 27'd1;
    if (!lat_rx) begin
      total = 27'd1 + 27'(payload_bytes(lat_cmd));
      if (lat_cmd == CMD_STREAM) total = total + {3'b000, lat_len};
    end
  end

  // Select the byte at position idx of the frame.
  always_comb begin
    byte_sel    = 8'h00;
    need_stream = 1'b0;
    if (lat_rx) begin
      byte_sel = 8'h00;
    end else if (idx == 27'd0) begin
      byte_sel = lat_cmd;
    end else begin
      case (lat_cmd)
        CMD_SET_CFG: begin
          case (idx[2:0])
            3'd1:    byte_sel = lat_arg[31:24];
            3'd2:    byte_sel = lat_arg[23:16];
            3'd3:    byte_sel = lat_arg[15:8];
            default: byte_sel = lat_arg[7:0];
          endcase
        end
        CMD_2B:      byte_sel = (idx[1:0] == 2'd1) ? lat_arg[15:8] : lat_arg[7:0];
        CMD_STREAM: begin
          if (idx >= 27'd4) begin
            byte_sel    = dat;
            need_stream = 1'b1;
          end else begin
            case (idx[1:0])
              2'd1:    byte_sel = lat_len[23:16];
              2'd2:    byte_sel = lat_len[15:8];
              default: byte_sel = lat_len[7:0];
            endcase
          end
        end
        default:     byte_sel = lat_arg[7:0];
      endcase
    end
  end

  // Frame FSM next state; byte loads happen in the same cycle the previous
  // byte finishes so bytes are back-to-back unless the stream stalls.
  always_comb begin
    state_n   = state;
    start     = 1'b0;
    dat_ready = 1'b0;
    avail     = ~need_stream | dat_valid;
    case (state)
      ST_IDLE:  if (accept) state_n = ST_SETUP;
      ST_SETUP: begin
        if (cnt == SETUP_LAST) begin
          start   = 1'b1;
          state_n = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (sh_done) begin
          if (idx == total) begin
            state_n = ST_END;
          end else if (avail) begin
            start     = 1'b1;
            dat_ready = need_stream;
          end else begin
            state_n = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (avail) begin
          start     = 1'b1;
          dat_ready = need_stream;
          state_n   = ST_SHIFT;
        end
      end
      ST_END:   if (cnt == END_LAST) state_n = ST_GAP;
      ST_GAP:   if (cnt == GAP_LAST) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // State register, phase counter and byte index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      armed <= 1'b0;
      cnt   <= 16'd0;
      idx   <= 27'd0;
    end else begin
      armed <= 1'b1;
      state <= state_n;
      cnt   <= (state_n != state) ? 16'd0 : cnt + 16'd1;
      if (accept)     idx <= 27'd0;
      else if (start) idx <= idx + 27'd1;
    end
  end

  // Request field capture and received-byte output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_rx   <= 1'b0;
      lat_cmd  <= 8'h00;
      lat_arg  <= 32'h0;
      lat_len  <= 24'h0;
      rx_valid <= 1'b0;
      rx_data  <= 8'h00;
    end else begin
      if (accept) begin
        lat_rx  <= req_rx;
        lat_cmd <= req_cmd;
        lat_arg <= req_arg;
        lat_len <= req_len;
      end
      rx_valid <= lat_rx & sh_rx_last;
      if (lat_rx & sh_rx_last) rx_data <= sh_rx_byte;
    end
  end

  sspi_shift_byte #(.CLK_DIV(CLK_DIV)) u_shift (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .tx_byte (byte_sel),
    .done    (sh_done),
    .rx_last (sh_rx_last),
    .rx_byte (sh_rx_byte),
    .sclk    (sspi_clk),
    .mosi    (sspi_mosi),
    .miso    (sspi_miso)
  );

endmodule
